// File: rtl/mlp_engine.sv
// mlp_engine: sequential MLP engine, one shared MAC, weights streamed from a sync ROM.
// Ports: clk, rst (async active-low), cfg_layers, in_* stream, w_rd/w_addr/w_data ROM,
//        out_* stream with out_last, busy, done.  Option macro: MLP_OUT_RELU_EN.
module mlp_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int DIM        = 8,
    parameter int NUM_LAYERS = 3,
    parameter int ACC_WIDTH  = 40,
    parameter int WADDR_W    = $clog2(NUM_LAYERS*DIM*(DIM+1))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            cfg_layers,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  w_rd,
    output logic [WADDR_W-1:0]    w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int KW = $clog2(DIM + 2);
    localparam int DW = DATA_WIDTH;
    localparam logic [3:0] NL = 4'(NUM_LAYERS);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IW-1:0]      r_beat;
    logic [IW-1:0]      r_neuron;
    logic [IW-1:0]      r_out;
    logic [KW-1:0]      r_k;
    logic [3:0]         r_layer;
    logic [3:0]         r_nlayers;
    logic [WADDR_W-1:0] r_addr;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [DW-1:0] r_buf_a [DIM];
    logic signed [DW-1:0] r_buf_b [DIM];

    logic                  w_in_fire;
    logic                  w_last_beat;
    logic                  w_k_last;
    logic                  w_neuron_last;
    logic                  w_final_layer;
    logic                  w_out_last;
    logic                  w_rd_int;
    logic [IW-1:0]         w_xidx;
    logic signed [DW-1:0]  w_x;
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0] w_acc_sum;
    logic signed [ACC_WIDTH-1:0] w_shift;
    logic signed [DW-1:0]  w_res;
    logic                  w_relu;
    logic [3:0]            w_cfg;
    logic signed [DW-1:0]  w_out_val;

    assign w_in_fire     = (r_state == S_LOAD) && in_valid;
    assign w_last_beat   = (r_beat == IW'(DIM - 1));
    assign w_k_last      = (r_k == KW'(DIM + 1));
    assign w_neuron_last = (r_neuron == IW'(DIM - 1));
    assign w_final_layer = (r_layer == (r_nlayers - 4'd1));
    assign w_out_last    = (r_out == IW'(DIM - 1));
    assign w_rd_int      = (r_state == S_COMPUTE) && !w_k_last;

    assign w_cfg = ((cfg_layers == 4'd0) || (cfg_layers > NL)) ? NL : cfg_layers;

    // ROM word k arrives at cycle k+1, so at cycle k the weight pairs with x[k-2].
    assign w_xidx    = IW'(r_k - KW'(2));
    assign w_x       = r_layer[0] ? r_buf_b[w_xidx] : r_buf_a[w_xidx];
    assign w_prod    = $signed(w_data) * w_x;
    assign w_acc_sum = r_acc + ACC_WIDTH'(w_prod);
    assign w_shift   = w_acc_sum >>> FRAC_BITS;

`ifdef MLP_OUT_RELU_EN
    assign w_relu = 1'b1;
`else
    assign w_relu = !w_final_layer;
`endif

    always_comb begin
        w_res = w_shift[DW-1:0];
        if (w_shift > SAT_MAX) begin
            w_res = {1'b0, {(DW-1){1'b1}}};
        end else if (w_shift < SAT_MIN) begin
            w_res = {1'b1, {(DW-1){1'b0}}};
        end
        if (w_relu && w_res[DW-1]) begin
            w_res = '0;
        end
    end

    // Odd layer counts leave the result in B, even counts in A.
    assign w_out_val = r_nlayers[0] ? r_buf_b[r_out] : r_buf_a[r_out];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_LOAD: begin
                if (w_in_fire && w_last_beat) begin
                    w_state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (w_k_last && w_neuron_last && w_final_layer) begin
                    w_state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready && w_out_last) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat    <= '0;
            r_neuron  <= '0;
            r_out     <= '0;
            r_k       <= '0;
            r_layer   <= '0;
            r_nlayers <= NL;
            r_addr    <= '0;
            r_acc     <= '0;
            for (int i = 0; i < DIM; i++) begin
                r_buf_a[i] <= '0;
                r_buf_b[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    r_addr <= '0;
                    if (w_in_fire) begin
                        r_buf_a[r_beat] <= $signed(in_data);
                        if (r_beat == '0) begin
                            r_nlayers <= w_cfg;
                        end
                        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    if (w_rd_int) begin
                        r_addr <= r_addr + 1'b1;
                    end
                    if (r_k == KW'(1)) begin
                        r_acc <= ACC_WIDTH'($signed(w_data)) <<< FRAC_BITS;
                    end else if (r_k > KW'(1)) begin
                        r_acc <= w_acc_sum;
                    end
                    if (w_k_last) begin
                        r_k <= '0;
                        if (r_layer[0]) begin
                            r_buf_a[r_neuron] <= w_res;
                        end else begin
                            r_buf_b[r_neuron] <= w_res;
                        end
                        if (w_neuron_last) begin
                            r_neuron <= '0;
                            r_layer  <= w_final_layer ? 4'd0 : r_layer + 4'd1;
                        end else begin
                            r_neuron <= r_neuron + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    r_addr <= '0;
                    if (out_ready) begin
                        r_out <= w_out_last ? '0 : r_out + 1'b1;
                    end
                end
                default: r_addr <= '0;
            endcase
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign busy      = (r_state != S_LOAD);
    assign w_rd      = w_rd_int;
    assign w_addr    = r_addr;
    assign out_valid = (r_state == S_OUTPUT);
    assign out_data  = out_valid ? w_out_val : '0;
    assign out_last  = out_valid && w_out_last;
    assign done      = out_valid && out_ready && w_out_last;

endmodule

// File: tb/tb_mlp_engine.sv
// tb_mlp_engine: directed vectors for mlp_engine with DIM=2, NUM_LAYERS=2.
// Behavioural ROM model; expected outputs are hand-computed constants.
module tb_mlp_engine;

    localparam int DW = 16;
    localparam int AW = 4;

`ifdef MLP_OUT_RELU_EN
    localparam logic [15:0] NEG_SAT = 16'h0000;
    localparam logic [15:0] NEG_ONE = 16'h0000;
`else
    localparam logic [15:0] NEG_SAT = 16'h8000;
    localparam logic [15:0] NEG_ONE = 16'hFF00;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    cfg_layers = 4'd2;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          w_rd;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rom [16];

    int n_tests = 0;
    int n_fail  = 0;

    mlp_engine #(
        .DATA_WIDTH(16),
        .FRAC_BITS(8),
        .DIM(2),
        .NUM_LAYERS(2),
        .ACC_WIDTH(40)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_layers(cfg_layers),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .w_rd(w_rd),
        .w_addr(w_addr),
        .w_data(w_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd) w_data <= rom[w_addr];
    end

    typedef struct {
        logic [3:0]  cfg;
        int          set;
        logic [15:0] x0;
        logic [15:0] x1;
        logic [15:0] e0;
        logic [15:0] e1;
        int          lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // addr = (l*2+j)*3+k; k=0 bias, k=1..2 weights
    task automatic load_rom(input int set);
        for (int a = 0; a < 16; a++) rom[a] = 16'h0000;
        for (int l = 0; l < 2; l++) begin
            for (int j = 0; j < 2; j++) begin
                for (int k = 0; k < 3; k++) begin
                    int a;
                    a = (l*2 + j)*3 + k;
                    case (set)
                        0: rom[a] = (k == j+1) ? 16'h0100 : 16'h0000;
                        1: begin
                            if (l == 1) rom[a] = (k == j+1) ? 16'h0100 : 16'h0000;
                            else if (j == 0 && k == 1) rom[a] = 16'hFF00;
                            else if (j == 1 && k == 2) rom[a] = 16'h0100;
                        end
                        2: rom[a] = (k == 0) ? 16'h0100 : 16'h7F00;
                        default: rom[a] = (k == 0) ? 16'h0100 : 16'h8000;
                    endcase
                end
            end
        end
    endtask

    task automatic send_frame(input logic [3:0] cfg, input logic [15:0] x0,
                              input logic [15:0] x1);
        cfg_layers = cfg;
        in_valid = 1'b1;
        in_data = x0;
        check("in_ready_beat0", in_ready, 1);
        @(posedge clk); #1;
        cfg_layers = 4'd5;
        in_data = x1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("in_ready_compute", in_ready, 0);
        check("busy_compute", busy, 1);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        load_rom(v.set);
        out_ready = 1'b1;
        send_frame(v.cfg, v.x0, v.x1);
        wait_out(n);
        check($sformatf("latency_v%0d", idx), n, v.lat);
        check($sformatf("beat0_data_v%0d", idx), out_data, v.e0);
        check($sformatf("beat0_last_v%0d", idx), {out_last, done}, 0);
        @(posedge clk); #1;
        check($sformatf("beat1_data_v%0d", idx), out_data, v.e1);
        check($sformatf("beat1_last_v%0d", idx), {out_valid, out_last, done}, 3'b111);
        @(posedge clk); #1;
        check($sformatf("post_frame_v%0d", idx), {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        int n;
        vecs[0] = '{4'd2, 0, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 16};
        vecs[1] = '{4'd2, 1, 16'h0100, 16'h0300, 16'h0000, 16'h0300, 16};
        vecs[2] = '{4'd1, 2, 16'h7F00, 16'h7F00, 16'h7FFF, 16'h7FFF, 8};
        vecs[3] = '{4'd1, 3, 16'h7F00, 16'h7F00, NEG_SAT, NEG_SAT, 8};
        vecs[4] = '{4'd0, 0, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 16};
        vecs[5] = '{4'd9, 0, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 16};
        vecs[6] = '{4'd1, 0, 16'hFF00, 16'h0200, NEG_ONE, 16'h0200, 8};
        vecs[7] = '{4'd2, 0, 16'hFF00, 16'h0200, 16'h0000, 16'h0200, 16};

        #2;
        check("reset_outs",
              {in_ready, out_valid, out_last, w_rd, busy, done}, 6'b100000);
        check("reset_data", out_data, 0);
        check("reset_addr", w_addr, 0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Back-pressure: hold out_ready low for 5 cycles
        load_rom(0);
        out_ready = 1'b0;
        send_frame(4'd2, 16'h0100, 16'h0200);
        wait_out(n);
        check("bp_latency", n, 16);
        for (int c = 0; c < 5; c++) begin
            check("bp_hold", {out_valid, out_last, done, out_data},
                  {3'b100, 16'h0100});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("bp_beat0", {out_last, done, out_data}, {2'b00, 16'h0100});
        @(posedge clk); #1;
        check("bp_beat1", {out_last, done, out_data}, {2'b11, 16'h0200});
        @(posedge clk); #1;
        check("bp_end", {out_valid, done}, 2'b00);

        // Reset during neuron 1 of layer 0
        send_frame(4'd2, 16'h0100, 16'h0200);
        repeat (5) @(posedge clk);
        #1;
        check("mid_w_rd", w_rd, 1);
        rst = 1'b0;
        #1;
        check("rst_mid", {out_valid, w_rd, busy, in_ready}, 4'b0001);
        check("rst_mid_addr", w_addr, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_rel_ready", in_ready, 1);
        run_vec(vecs[0], 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
